// File: rtl/cut_vector_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// nbgen_test_pkg
// Definitions shared by the test-application slice around a combinational
// benchmark CUT (default widths are those of Circuit432).
//   - seq_state_e : sequencer FSM states
//   - misr_next() : one MISR compaction step, width and polynomial as arguments
// -----------------------------------------------------------------------------
package nbgen_test_pkg;

    // Circuit432 interface widths.
    localparam int C432_PI_WIDTH = 36;
    localparam int C432_PO_WIDTH = 7;

    // Widest signature misr_next() can handle.
    localparam int MISR_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VEC,
        ST_SETTLE,
        ST_DONE
    } seq_state_e;

    // Shift left by one, fold in the polynomial when the MSB falls off, then
    // XOR the (zero-extended) response. Everything is carried at the maximum
    // width and masked back down to 'width' bits.
    function automatic logic [MISR_MAX_WIDTH-1:0] misr_next(
        input logic [MISR_MAX_WIDTH-1:0] sig,
        input logic [MISR_MAX_WIDTH-1:0] din,
        input logic [MISR_MAX_WIDTH-1:0] poly,
        input int unsigned               width
    );
        logic [MISR_MAX_WIDTH-1:0] mask;
        logic [MISR_MAX_WIDTH-1:0] shifted;
        logic                      msb;
        mask    = (width >= MISR_MAX_WIDTH) ? '1
                                            : ((64'd1 << width) - 64'd1);
        msb     = |(sig & (64'd1 << (width - 1)));
        shifted = (sig << 1) & mask;
        if (msb) begin
            shifted = shifted ^ (poly & mask);
        end
        return (shifted ^ din) & mask;
    endfunction

endpackage

// File: rtl/cut_vector_sequencer_if.sv
// -----------------------------------------------------------------------------
// cut_vector_sequencer_if
// Ready/valid test-vector stream into the sequencer.
//   vec_valid : upstream has a vector
//   vec_ready : sequencer can take it
//   vec_data  : test vector, MSB maps to the first CUT input
//   vec_last  : final vector of the session
// Modports: master = vector source, slave = sequencer.
// -----------------------------------------------------------------------------
interface cut_vector_sequencer_if #(
    parameter int PI_WIDTH = nbgen_test_pkg::C432_PI_WIDTH
);
    logic                vec_valid;
    logic                vec_ready;
    logic [PI_WIDTH-1:0] vec_data;
    logic                vec_last;

    modport master (
        output vec_valid,
        output vec_data,
        output vec_last,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  vec_data,
        input  vec_last,
        output vec_ready
    );
endinterface

// File: rtl/cut_vector_sequencer_misr_compactor.sv
// -----------------------------------------------------------------------------
// misr_compactor
// Multiple-input signature register folding one response per enabled cycle.
//   clk, rst : clock, asynchronous active-high reset (loads MISR_SEED)
//   clear    : synchronous reload of MISR_SEED (session start)
//   en       : compact din into the signature this edge
//   din      : response word, zero-extended to MISR_WIDTH
//   sig      : current signature
// -----------------------------------------------------------------------------
module misr_compactor
    import nbgen_test_pkg::*;
#(
    parameter int                    MISR_WIDTH = 16,
    parameter logic [MISR_WIDTH-1:0] MISR_POLY  = 16'h1021,
    parameter logic [MISR_WIDTH-1:0] MISR_SEED  = 16'h0000,
    parameter int                    IN_WIDTH   = C432_PO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [IN_WIDTH-1:0]   din,
    output logic [MISR_WIDTH-1:0] sig
);

    logic [MISR_MAX_WIDTH-1:0] sig_next_wide;

    always_comb begin
        sig_next_wide = misr_next(MISR_MAX_WIDTH'(sig), MISR_MAX_WIDTH'(din),
                                  MISR_MAX_WIDTH'(MISR_POLY), MISR_WIDTH);
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples its inputs as they were before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= MISR_SEED;
        end else if (clear) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= sig_next_wide[MISR_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cut_vector_sequencer.sv
// -----------------------------------------------------------------------------
// cut_vector_sequencer
// Applies test vectors from a ready/valid stream to a combinational CUT, waits
// SETTLE_CYCLES edges, samples the CUT outputs, publishes each response and
// compacts all responses of a session into a MISR signature.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : session start pulse, honoured in IDLE or DONE only
//   vec        : vector stream (slave side)
//   cut_pi     : registered CUT primary-input drive
//   cut_po     : CUT primary outputs
//   resp_valid : one-cycle strobe, resp_data/resp_index freshly captured
//   resp_data  : captured response
//   resp_index : 0-based index of that vector
//   signature  : running MISR value
//   vec_count  : vectors completed this session
//   busy       : WAIT_VEC or SETTLE
//   done       : DONE
// -----------------------------------------------------------------------------
module cut_vector_sequencer
    import nbgen_test_pkg::*;
#(
    parameter int                    PI_WIDTH      = C432_PI_WIDTH,
    parameter int                    PO_WIDTH      = C432_PO_WIDTH,
    parameter int                    SETTLE_CYCLES = 2,
    parameter int                    MAX_VECTORS   = 32,
    parameter int                    MISR_WIDTH    = 16,
    parameter logic [MISR_WIDTH-1:0] MISR_POLY     = 16'h1021,
    parameter logic [MISR_WIDTH-1:0] MISR_SEED     = 16'h0000,
    localparam int                   CNT_W         = $clog2(MAX_VECTORS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    cut_vector_sequencer_if.slave       vec,
    output logic [PI_WIDTH-1:0]         cut_pi,
    input  logic [PO_WIDTH-1:0]         cut_po,
    output logic                        resp_valid,
    output logic [PO_WIDTH-1:0]         resp_data,
    output logic [CNT_W-1:0]            resp_index,
    output logic [MISR_WIDTH-1:0]       signature,
    output logic [CNT_W-1:0]            vec_count,
    output logic                        busy,
    output logic                        done
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    seq_state_e          state;
    seq_state_e          state_next;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                last_flag;
    logic                accept;
    logic                sample;
    logic                begin_session;
    logic                final_vec;

    assign accept        = vec.vec_valid & vec.vec_ready;
    assign begin_session = start & ((state == ST_IDLE) | (state == ST_DONE));
    // The counter is loaded with SETTLE_CYCLES at the handshake edge, so the
    // edge on which it reads 1 is exactly SETTLE_CYCLES edges later.
    assign sample        = (state == ST_SETTLE) && (settle_cnt == SETTLE_W'(1));
    // Forced completion and vec_last on the final allowed vector both land here,
    // giving a single transition into DONE.
    assign final_vec     = last_flag || (vec_count == CNT_W'(MAX_VECTORS - 1));

    // State register.
    // NOTE: every control and datapath register has an async reset value, so a
    // mid-session rst leaves no partial session state behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: each always_comb output gets a default on entry; otherwise paths
    // that do not assign it would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (begin_session) state_next = ST_WAIT_VEC;
            ST_WAIT_VEC:      if (accept)        state_next = ST_SETTLE;
            ST_SETTLE:        if (sample)        state_next = final_vec ? ST_DONE : ST_WAIT_VEC;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        vec.vec_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (state)
            ST_WAIT_VEC: begin
                vec.vec_ready = 1'b1;
                busy          = 1'b1;
            end
            ST_SETTLE:   busy = 1'b1;
            ST_DONE:     done = 1'b1;
            default:     ;
        endcase
    end

    // Vector drive, settle timing, response capture and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cut_pi     <= '0;
            last_flag  <= 1'b0;
            settle_cnt <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_index <= '0;
            vec_count  <= '0;
        end else begin
            resp_valid <= sample;

            if (begin_session) begin
                vec_count <= '0;
            end

            // cut_pi moves only on an accepted handshake, keeping the CUT
            // inputs stable through the whole settle window.
            if (accept) begin
                cut_pi     <= vec.vec_data;
                last_flag  <= vec.vec_last;
                settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end

            if (sample) begin
                resp_data  <= cut_po;
                resp_index <= vec_count;
                vec_count  <= vec_count + CNT_W'(1);
            end
        end
    end

    misr_compactor #(
        .MISR_WIDTH (MISR_WIDTH),
        .MISR_POLY  (MISR_POLY),
        .MISR_SEED  (MISR_SEED),
        .IN_WIDTH   (PO_WIDTH)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear (begin_session),
        .en    (sample),
        .din   (cut_po),
        .sig   (signature)
    );

endmodule
